// File: rtl/b200_rst_pkg.sv
// b200_rst_pkg: shared types and constants for the bus_clk reset sequencer.
//   seq_state_e   - sequencer state encoding, also exported on seq_state
//   seq_outs_t    - bundle of the five registered reset/ready outputs
//   seq_outs()    - output values that belong to a given state
//   seq_next_st() - next release stage after a stage gap expires
package b200_rst_pkg;

  localparam int STAGE_CNT_W = 16;
  localparam int LOSS_CNT_W  = 8;

  // Encoding 7 is named only so it can be handled explicitly; it is never
  // entered on purpose and recovers to WAIT_LOCK.
  typedef enum logic [2:0] {
    SEQ_WAIT_LOCK = 3'd0,
    SEQ_HOLDOFF   = 3'd1,
    SEQ_REL_CODEC = 3'd2,
    SEQ_REL_GPIF  = 3'd3,
    SEQ_REL_BUS   = 3'd4,
    SEQ_REL_RADIO = 3'd5,
    SEQ_RUN       = 3'd6,
    SEQ_ILLEGAL   = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic codec_reset_n;
    logic gpif_rst_req;
    logic bus_rst_req;
    logic radio_rst_req;
    logic clocks_ready;
  } seq_outs_t;

  localparam seq_outs_t SEQ_OUTS_RESET = '{
    codec_reset_n: 1'b0, gpif_rst_req: 1'b1, bus_rst_req: 1'b1,
    radio_rst_req: 1'b1, clocks_ready: 1'b0};

  // Each stage keeps every release made by the stages before it.
  function automatic seq_outs_t seq_outs(input seq_state_e s);
    seq_outs_t o;
    o = SEQ_OUTS_RESET;
    o.codec_reset_n = s inside {SEQ_REL_CODEC, SEQ_REL_GPIF, SEQ_REL_BUS, SEQ_REL_RADIO, SEQ_RUN};
    o.gpif_rst_req  = !(s inside {SEQ_REL_GPIF, SEQ_REL_BUS, SEQ_REL_RADIO, SEQ_RUN});
    o.bus_rst_req   = !(s inside {SEQ_REL_BUS, SEQ_REL_RADIO, SEQ_RUN});
    o.radio_rst_req = !(s inside {SEQ_REL_RADIO, SEQ_RUN});
    o.clocks_ready  = (s == SEQ_RUN);
    return o;
  endfunction

  function automatic seq_state_e seq_next_st(input seq_state_e s);
    case (s)
      SEQ_REL_CODEC: return SEQ_REL_GPIF;
      SEQ_REL_GPIF:  return SEQ_REL_BUS;
      SEQ_REL_BUS:   return SEQ_REL_RADIO;
      SEQ_REL_RADIO: return SEQ_RUN;
      default:       return SEQ_WAIT_LOCK;
    endcase
  endfunction

endpackage

// File: rtl/b200_clk_rst_seq_if.sv
// b200_clk_rst_seq_if: signal bundle between the reset sequencer and its
// surroundings.
//   locked, soft_reseq          - inputs to the sequencer (async / level)
//   codec_reset_n, *_rst_req    - staged reset outputs
//   clocks_ready                - all stages released
//   seq_state, lock_loss_cnt    - readback for rb_misc
// modport master: the sequencer side; modport slave: the consumer side.
interface b200_clk_rst_seq_if;
  import b200_rst_pkg::*;

  logic                  locked;
  logic                  soft_reseq;
  logic                  codec_reset_n;
  logic                  gpif_rst_req;
  logic                  bus_rst_req;
  logic                  radio_rst_req;
  logic                  clocks_ready;
  logic [2:0]            seq_state;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  locked, soft_reseq,
    output codec_reset_n, gpif_rst_req, bus_rst_req, radio_rst_req,
           clocks_ready, seq_state, lock_loss_cnt
  );

  modport slave (
    output locked, soft_reseq,
    input  codec_reset_n, gpif_rst_req, bus_rst_req, radio_rst_req,
           clocks_ready, seq_state, lock_loss_cnt
  );
endinterface

// File: rtl/b200_clk_rst_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for signals asynchronous to clk.
//   clk - destination clock
//   clr - asynchronous active-high clear of both stages
//   d   - asynchronous input (W bits, each bit synchronized independently)
//   q   - synchronized output, two clk edges behind d
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_reg <= '0;
      q        <= '0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/b200_clk_rst_seq.sv
// b200_clk_rst_seq: staged reset release after MMCM lock.
//   bus_clk      - sequencer clock
//   reset_global - asynchronous active-high global reset
//   bus          - b200_clk_rst_seq_if.master (locked/soft_reseq in, staged
//                  resets, clocks_ready, seq_state and lock_loss_cnt out)
// Order of release: codec, gpif, bus, radio, then clocks_ready. A filtered
// lock loss or a soft_reseq rising edge drops everything back to WAIT_LOCK.
module b200_clk_rst_seq
  import b200_rst_pkg::*;
#(
  parameter int HOLDOFF_W   = 16,
  parameter int STAGE_GAP   = 256,
  parameter int GLITCH_FILT = 4
) (
  input logic                 bus_clk,
  input logic                 reset_global,
  b200_clk_rst_seq_if.master  bus
);

  localparam int LOW_W = 4;

  logic                   lk_s;
  logic                   reseq_s;
  logic                   reseq_prev_reg;
  logic                   reseq_rise;
  logic [LOW_W-1:0]       low_cnt_reg;
  logic                   lock_loss;
  seq_state_e             state_reg;
  seq_outs_t              outs_reg;
  logic [HOLDOFF_W-1:0]   hold_cnt_reg;
  logic [STAGE_CNT_W-1:0] stage_cnt_reg;
  logic [LOSS_CNT_W-1:0]  loss_cnt_reg;

  sync_2ff #(.W(1)) u_sync_locked (
    .clk (bus_clk), .clr (reset_global), .d (bus.locked), .q (lk_s)
  );

  sync_2ff #(.W(1)) u_sync_reseq (
    .clk (bus_clk), .clr (reset_global), .d (bus.soft_reseq), .q (reseq_s)
  );

  // Glitch filter: run length of synchronized-low cycles, saturating.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      low_cnt_reg    <= '0;
      reseq_prev_reg <= 1'b0;
    end else begin
      reseq_prev_reg <= reseq_s;
      if (lk_s)
        low_cnt_reg <= '0;
      else if (low_cnt_reg != LOW_W'(GLITCH_FILT))
        low_cnt_reg <= low_cnt_reg + 1'b1;
    end
  end

  assign reseq_rise = reseq_s && !reseq_prev_reg;
  // Loss fires on the edge where the run length reaches GLITCH_FILT.
  assign lock_loss  = !lk_s && (low_cnt_reg == LOW_W'(GLITCH_FILT - 1)) &&
                      (state_reg != SEQ_WAIT_LOCK);

  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state_reg     <= SEQ_WAIT_LOCK;
      outs_reg      <= SEQ_OUTS_RESET;
      hold_cnt_reg  <= '0;
      stage_cnt_reg <= '0;
      loss_cnt_reg  <= '0;
    end else if (lock_loss || (reseq_rise && state_reg != SEQ_WAIT_LOCK)) begin
      state_reg     <= SEQ_WAIT_LOCK;
      outs_reg      <= SEQ_OUTS_RESET;
      hold_cnt_reg  <= '0;
      stage_cnt_reg <= '0;
      // A simultaneous soft request still counts only as the single loss.
      if (lock_loss && loss_cnt_reg != '1)
        loss_cnt_reg <= loss_cnt_reg + 1'b1;
    end else begin
      case (state_reg)
        SEQ_WAIT_LOCK: begin
          hold_cnt_reg  <= '0;
          stage_cnt_reg <= '0;
          if (lk_s) begin
            state_reg <= SEQ_HOLDOFF;
            outs_reg  <= seq_outs(SEQ_HOLDOFF);
          end
        end
        SEQ_HOLDOFF: begin
          if (&hold_cnt_reg) begin
            hold_cnt_reg <= '0;
            state_reg    <= SEQ_REL_CODEC;
            outs_reg     <= seq_outs(SEQ_REL_CODEC);
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        SEQ_REL_CODEC, SEQ_REL_GPIF, SEQ_REL_BUS, SEQ_REL_RADIO: begin
          if (stage_cnt_reg == STAGE_CNT_W'(STAGE_GAP - 1)) begin
            stage_cnt_reg <= '0;
            state_reg     <= seq_next_st(state_reg);
            outs_reg      <= seq_outs(seq_next_st(state_reg));
          end else begin
            stage_cnt_reg <= stage_cnt_reg + 1'b1;
          end
        end
        SEQ_RUN: begin
          stage_cnt_reg <= '0;
        end
        default: begin
          state_reg     <= SEQ_WAIT_LOCK;
          outs_reg      <= SEQ_OUTS_RESET;
          hold_cnt_reg  <= '0;
          stage_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign bus.codec_reset_n = outs_reg.codec_reset_n;
  assign bus.gpif_rst_req  = outs_reg.gpif_rst_req;
  assign bus.bus_rst_req   = outs_reg.bus_rst_req;
  assign bus.radio_rst_req = outs_reg.radio_rst_req;
  assign bus.clocks_ready  = outs_reg.clocks_ready;
  assign bus.seq_state     = state_reg;
  assign bus.lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_b200_clk_rst_seq.sv
// tb_b200_clk_rst_seq: self-checking bench for b200_clk_rst_seq with
// HOLDOFF_W=4, STAGE_GAP=8, GLITCH_FILT=4. A timeline model (elapsed cycles
// since lock) predicts every output each cycle; directed sequences and a
// glitch-length table cover the corner cases.
module tb_b200_clk_rst_seq;
  import b200_rst_pkg::*;

  localparam int HW = 4;
  localparam int GAP = 8;
  localparam int GF = 4;
  localparam int HOLD_LEN = 1 << HW;

  logic bus_clk = 1'b0;
  logic reset_global;
  always #5 bus_clk = ~bus_clk;

  b200_clk_rst_seq_if bus ();

  b200_clk_rst_seq #(.HOLDOFF_W(HW), .STAGE_GAP(GAP), .GLITCH_FILT(GF)) dut (
    .bus_clk      (bus_clk),
    .reset_global (reset_global),
    .bus          (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Input history pipelines, low run length, and a timeline: when active,
  // m_t counts cycles since HOLDOFF was entered; outputs follow from m_t.
  bit m_l1, m_l2, m_r1, m_r2, m_r3;
  int m_low, m_t, m_loss;
  bit m_active;

  function automatic void model_reset();
    m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0;
    m_low = 0; m_t = 0; m_loss = 0; m_active = 0;
  endfunction

  function automatic void model_edge();
    bit lk_s, rise, loss;
    lk_s = m_l2;
    rise = m_r2 && !m_r3;
    loss = m_active && !lk_s && (m_low == GF - 1);
    if (loss || (m_active && rise)) begin
      m_active = 0;
      m_t = 0;
      if (loss && m_loss < 255) m_loss++;
    end else if (m_active) begin
      if (m_t < 1000000) m_t++;
    end else if (lk_s) begin
      m_active = 1;
      m_t = 0;
    end
    m_low = lk_s ? 0 : ((m_low < GF) ? m_low + 1 : GF);
    m_l2 = m_l1; m_l1 = bus.locked;
    m_r3 = m_r2; m_r2 = m_r1; m_r1 = bus.soft_reseq;
  endfunction

  function automatic int model_state();
    int k;
    if (!m_active) return 0;
    if (m_t < HOLD_LEN) return 1;
    k = (m_t - HOLD_LEN) / GAP;
    return (k >= 4) ? 6 : 2 + k;
  endfunction

  function automatic logic [15:0] model_vec();
    int s;
    s = model_state();
    return {(s >= 2) ? 1'b1 : 1'b0, (s >= 3) ? 1'b0 : 1'b1, (s >= 4) ? 1'b0 : 1'b1,
            (s >= 5) ? 1'b0 : 1'b1, (s == 6) ? 1'b1 : 1'b0, 3'(s), 8'(m_loss)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.codec_reset_n, bus.gpif_rst_req, bus.bus_rst_req, bus.radio_rst_req,
            bus.clocks_ready, bus.seq_state, bus.lock_loss_cnt};
  endfunction

  // One clock: model advances on the edge, DUT compared 1 time unit later,
  // returns at the following negedge where the caller drives inputs.
  task automatic cycle();
    logic [15:0] e, a;
    @(posedge bus_clk);
    if (reset_global) model_reset(); else model_edge();
    #1;
    e = model_vec();
    a = dut_vec();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL model: got %h, expected %h (t=%0t)", a, e, $time);
    end
    @(negedge bus_clk);
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (bus.seq_state != 3'(target) && n < budget) begin
      cycle();
      n++;
    end
    check(name, int'(bus.seq_state), target);
  endtask

  typedef struct {
    int low_len;
    int exp_ready;
    int exp_loss_delta;
  } glitch_vec_t;

  glitch_vec_t gv [5];

  initial begin
    int base;
    gv[0] = '{1, 1, 0};
    gv[1] = '{2, 1, 0};
    gv[2] = '{3, 1, 0};
    gv[3] = '{4, 0, 1};
    gv[4] = '{7, 0, 1};

    reset_global = 1'b1;
    bus.locked = 1'b0;
    bus.soft_reseq = 1'b0;
    model_reset();
    repeat (3) @(negedge bus_clk);
    check("rst_codec_reset_n", int'(bus.codec_reset_n), 0);
    check("rst_gpif_rst_req", int'(bus.gpif_rst_req), 1);
    check("rst_bus_rst_req", int'(bus.bus_rst_req), 1);
    check("rst_radio_rst_req", int'(bus.radio_rst_req), 1);
    check("rst_clocks_ready", int'(bus.clocks_ready), 0);
    check("rst_seq_state", int'(bus.seq_state), 0);
    check("rst_lock_loss_cnt", int'(bus.lock_loss_cnt), 0);
    reset_global = 1'b0;

    // First lock: exact release timeline relative to the locked rise.
    repeat (10) cycle();
    bus.locked = 1'b1;
    for (int e = 1; e <= 52; e++) begin
      cycle();
      case (e)
        2:  check("pre_holdoff_state", int'(bus.seq_state), 0);
        3:  check("holdoff_entry", int'(bus.seq_state), 1);
        18: check("codec_held", int'(bus.codec_reset_n), 0);
        19: check("codec_release", int'(bus.codec_reset_n), 1);
        26: check("gpif_held", int'(bus.gpif_rst_req), 1);
        27: check("gpif_release", int'(bus.gpif_rst_req), 0);
        35: check("bus_release", int'(bus.bus_rst_req), 0);
        43: check("radio_release", int'(bus.radio_rst_req), 0);
        50: check("ready_held", int'(bus.clocks_ready), 0);
        51: check("ready_set", int'(bus.clocks_ready), 1);
        52: check("run_state", int'(bus.seq_state), 6);
        default: ;
      endcase
    end
    $display("first lock: seq_state=%0d clocks_ready=%0d", bus.seq_state, bus.clocks_ready);

    // Glitch-length table, each applied from RUN.
    for (int i = 0; i < 5; i++) begin
      wait_state(6, 200, "glitch_reach_run");
      base = int'(bus.lock_loss_cnt);
      bus.locked = 1'b0;
      repeat (gv[i].low_len) cycle();
      bus.locked = 1'b1;
      repeat (3) cycle();
      check("glitch_ready", int'(bus.clocks_ready), gv[i].exp_ready);
      check("glitch_loss_delta", int'(bus.lock_loss_cnt) - base, gv[i].exp_loss_delta);
      $display("glitch len=%0d ready=%0d lock_loss_cnt=%0d", gv[i].low_len,
               bus.clocks_ready, bus.lock_loss_cnt);
    end

    // Soft re-sequence during REL_BUS (sequence restarting after last loss).
    wait_state(4, 200, "reach_rel_bus");
    base = int'(bus.lock_loss_cnt);
    bus.soft_reseq = 1'b1;
    cycle();
    cycle();
    check("reseq_not_yet", int'(bus.seq_state), 4);
    cycle();
    check("reseq_state", int'(bus.seq_state), 0);
    check("reseq_codec", int'(bus.codec_reset_n), 0);
    check("reseq_cnt", int'(bus.lock_loss_cnt), base);
    wait_state(6, 200, "reseq_completes");
    bus.soft_reseq = 1'b0;
    repeat (5) cycle();
    $display("soft reseq: seq_state=%0d lock_loss_cnt=%0d", bus.seq_state, bus.lock_loss_cnt);

    // Randomized lock activity and soft requests against the model.
    for (int k = 0; k < 60; k++) begin
      bus.locked = 1'b1;
      repeat ($urandom_range(10, 90)) cycle();
      if ($urandom_range(0, 3) == 0) bus.soft_reseq = ~bus.soft_reseq;
      bus.locked = 1'b0;
      repeat ($urandom_range(1, 6)) cycle();
    end
    bus.soft_reseq = 1'b0;
    $display("random: lock_loss_cnt=%0d", bus.lock_loss_cnt);

    // 300 forced losses saturate the counter.
    for (int k = 0; k < 300; k++) begin
      bus.locked = 1'b1;
      repeat (4) cycle();
      bus.locked = 1'b0;
      repeat (6) cycle();
    end
    check("loss_saturate", int'(bus.lock_loss_cnt), 255);
    $display("saturation: lock_loss_cnt=%0d", bus.lock_loss_cnt);

    // Asynchronous reset mid-HOLDOFF.
    bus.locked = 1'b1;
    repeat (5) cycle();
    check("pre_reset_holdoff", int'(bus.seq_state), 1);
    reset_global = 1'b1;
    #1;
    check("areset_codec", int'(bus.codec_reset_n), 0);
    check("areset_gpif", int'(bus.gpif_rst_req), 1);
    check("areset_radio", int'(bus.radio_rst_req), 1);
    check("areset_state", int'(bus.seq_state), 0);
    check("areset_cnt", int'(bus.lock_loss_cnt), 0);
    model_reset();
    cycle();
    reset_global = 1'b0;
    wait_state(6, 200, "post_reset_run");
    $display("reset mid-holdoff: lock_loss_cnt=%0d", bus.lock_loss_cnt);

    // Illegal encoding recovers to WAIT_LOCK.
    bus.locked = 1'b0;
    repeat (10) cycle();
    force dut.state_reg = SEQ_ILLEGAL;
    #1;
    release dut.state_reg;
    cycle();
    check("illegal_recover", int'(bus.seq_state), 0);
    check("illegal_codec", int'(bus.codec_reset_n), 0);
    check("illegal_ready", int'(bus.clocks_ready), 0);
    $display("illegal state: seq_state=%0d", bus.seq_state);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
